// File: rtl/alu181_pkg.sv
// Shared constants and types for the 74181-style ALU slice.
package alu181_pkg;

  // Function selects that are commonly used by callers
  localparam logic [3:0] ALU_S_ADD  = 4'd9;   // arithmetic: A plus B
  localparam logic [3:0] ALU_S_SUB  = 4'd6;   // arithmetic: A minus B minus 1 (plus 1 with carry in)
  localparam logic [3:0] ALU_S_XOR  = 4'd6;   // logic: A xor B
  localparam logic [3:0] ALU_S_ONES = 4'd12;  // logic: constant 1111

  // Mode select values
  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  // Output bundle of one slice
  typedef struct packed {
    logic [3:0] f;
    logic       x;     // group propagate, active-low
    logic       y;     // group generate, active-low
    logic       cn4b;  // carry out, active-low
    logic       aeb;   // F is all ones
  } alu_out_t;

endpackage

// File: rtl/alu181_core.sv
// Combinational 74181 datapath: per-bit u/v terms, 4-bit sum with carry,
// group propagate/generate and the A=B flag.
module alu181_core
  import alu181_pkg::*;
(
  input  logic [3:0] s_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       m_i,
  input  logic       cnb_i,
  output alu_out_t   out_o
);

  logic [3:0] u;
  logic [3:0] v;
  logic [4:0] sum;
  logic [3:0] f_int;

  // u is the per-bit propagate-like term, v the per-bit generate-like term;
  // v can only be set where u is set, so u + v never double counts.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign u[gi] = a_i[gi] | (b_i[gi] & s_i[0]) | (~b_i[gi] & s_i[1]);
    assign v[gi] = (a_i[gi] & ~b_i[gi] & s_i[2]) | (a_i[gi] & b_i[gi] & s_i[3]);
  end

  assign sum   = {1'b0, u} + {1'b0, v} + {4'b0000, ~cnb_i};
  assign f_int = (m_i == MODE_LOGIC) ? ~(u ^ v) : sum[3:0];

  // Assemble the output bundle; carry out is produced in both modes
  always_comb begin
    out_o      = '0;
    out_o.f    = f_int;
    out_o.cn4b = ~sum[4];
    out_o.x    = ~(&u);
    out_o.y    = ~(v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]));
    out_o.aeb  = &f_int;
  end

endmodule

// File: rtl/circuit_74181b.sv
// 74181 ALU slice top level. Define CIRCUIT_74181B_OUTREG_EN to register all
// outputs (one cycle latency, async active-low reset); otherwise the outputs
// are purely combinational and clk/rst_n are not used.
module circuit_74181b
  import alu181_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  input  logic       CNb,
  output logic [3:0] F,
  output logic       X,
  output logic       Y,
  output logic       CN4b,
  output logic       AEB
);

  alu_out_t out_d;

  alu181_core u_core (
    .s_i   (S),
    .a_i   (A),
    .b_i   (B),
    .m_i   (M),
    .cnb_i (CNb),
    .out_o (out_d)
  );

`ifdef CIRCUIT_74181B_OUTREG_EN
  localparam alu_out_t RESET_OUT = '{f: 4'b0000, x: 1'b1, y: 1'b1, cn4b: 1'b1, aeb: 1'b0};

  alu_out_t out_q;

  // All outputs captured together from one sampled input set; AEB comes from
  // the same next value as F so it never lags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= RESET_OUT;
    else        out_q <= out_d;
  end

  assign F    = out_q.f;
  assign X    = out_q.x;
  assign Y    = out_q.y;
  assign CN4b = out_q.cn4b;
  assign AEB  = out_q.aeb;
`else
  // Clock and reset have no function in the combinational build
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign F    = out_d.f;
  assign X    = out_d.x;
  assign Y    = out_d.y;
  assign CN4b = out_d.cn4b;
  assign AEB  = out_d.aeb;
`endif

endmodule

// File: tb/tb_circuit_74181b.sv
// Self-checking bench for circuit_74181b: directed vector table, exhaustive
// sweep, random vectors and (registered build) reset sequences.
module tb_circuit_74181b;
  import alu181_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] S, A, B;
  logic       M, CNb;
  logic [3:0] F;
  logic       X, Y, CN4b, AEB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] f;
    logic       x, y, cn4b, aeb;
  } exp_t;

  typedef struct {
    logic [3:0] s, a, b;
    logic       m, cnb;
    exp_t       e;
  } vec_t;

  circuit_74181b dut (
    .clk(clk), .rst_n(rst_n), .S(S), .A(A), .B(B), .M(M), .CNb(CNb),
    .F(F), .X(X), .Y(Y), .CN4b(CN4b), .AEB(AEB)
  );

  always #5 clk = ~clk;

  // Reference model built from the function tables: the arithmetic result is
  // "first operand + second operand + carry" with -1 taken as +15.
  function automatic exp_t model(input logic [3:0] s, a, b, input logic m, cnb);
    exp_t r;
    logic [3:0] p, q, lf;
    int total;
    case (s[1:0])
      2'd0: p = a;
      2'd1: p = a | b;
      2'd2: p = a | ~b;
      default: p = 4'd15;
    endcase
    case (s[3:2])
      2'd0: q = 4'd0;
      2'd1: q = a & ~b;
      2'd2: q = a & b;
      default: q = a;
    endcase
    total = int'(p) + int'(q) + (cnb ? 0 : 1);
    case (s)
      4'd0:  lf = ~a;
      4'd1:  lf = ~(a | b);
      4'd2:  lf = ~a & b;
      4'd3:  lf = 4'd0;
      4'd4:  lf = ~(a & b);
      4'd5:  lf = ~b;
      4'd6:  lf = a ^ b;
      4'd7:  lf = a & ~b;
      4'd8:  lf = ~a | b;
      4'd9:  lf = ~(a ^ b);
      4'd10: lf = b;
      4'd11: lf = a & b;
      4'd12: lf = 4'b1111;
      4'd13: lf = a | ~b;
      4'd14: lf = a | b;
      default: lf = a;
    endcase
    r.f    = m ? lf : 4'(total % 16);
    r.cn4b = !(total >= 16);
    r.x    = !(p == 4'd15);
    r.y    = !((int'(p) + int'(q)) >= 16);
    r.aeb  = (r.f == 4'd15);
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (S=%0d M=%b CNb=%b A=%0d B=%0d)",
               name, act, req, S, M, CNb, A, B);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".F"},    F,           e.f);
    chk({tag, ".X"},    {3'b0, X},    {3'b0, e.x});
    chk({tag, ".Y"},    {3'b0, Y},    {3'b0, e.y});
    chk({tag, ".CN4b"}, {3'b0, CN4b}, {3'b0, e.cn4b});
    chk({tag, ".AEB"},  {3'b0, AEB},  {3'b0, e.aeb});
  endtask

  // Drive a vector and wait until its result is visible on the outputs
  task automatic apply(input logic [3:0] s, a, b, input logic m, cnb);
    @(negedge clk);
    S = s; A = a; B = b; M = m; CNb = cnb;
`ifdef CIRCUIT_74181B_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  vec_t tbl[6];
  exp_t rst_e;

  initial begin
    rst_e = '{f: 4'b0000, x: 1'b1, y: 1'b1, cn4b: 1'b1, aeb: 1'b0};
    tbl[0] = '{s: ALU_S_ADD, a: 4'd3,  b: 4'd5, m: MODE_ARITH, cnb: 1'b1,
               e: '{f: 4'b1000, x: 1'b1, y: 1'b1, cn4b: 1'b1, aeb: 1'b0}};
    tbl[1] = '{s: ALU_S_ADD, a: 4'd15, b: 4'd1, m: MODE_ARITH, cnb: 1'b1,
               e: '{f: 4'b0000, x: 1'b0, y: 1'b0, cn4b: 1'b0, aeb: 1'b0}};
    tbl[2] = '{s: ALU_S_SUB, a: 4'd3,  b: 4'd5, m: MODE_ARITH, cnb: 1'b1,
               e: '{f: 4'b1101, x: 1'b1, y: 1'b1, cn4b: 1'b1, aeb: 1'b0}};
    tbl[3] = '{s: ALU_S_SUB, a: 4'd5,  b: 4'd3, m: MODE_ARITH, cnb: 1'b0,
               e: '{f: 4'b0010, x: 1'b1, y: 1'b0, cn4b: 1'b0, aeb: 1'b0}};
    tbl[4] = '{s: ALU_S_SUB, a: 4'd7,  b: 4'd7, m: MODE_ARITH, cnb: 1'b1,
               e: '{f: 4'b1111, x: 1'b0, y: 1'b1, cn4b: 1'b1, aeb: 1'b1}};
    tbl[5] = '{s: ALU_S_XOR, a: 4'd3,  b: 4'd5, m: MODE_LOGIC, cnb: 1'b1,
               e: '{f: 4'b0110, x: 1'b1, y: 1'b1, cn4b: 1'b1, aeb: 1'b0}};

    // Reset held with arbitrary inputs applied
    rst_n = 1'b0;
    S = 4'd9; A = 4'd15; B = 4'd1; M = 1'b0; CNb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef CIRCUIT_74181B_OUTREG_EN
    chk_all("reset", rst_e);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].cnb);
      chk_all($sformatf("vec%0d", i), tbl[i].e);
      $display("vec%0d S=%0d M=%b CNb=%b A=%0d B=%0d -> F=%b X=%b Y=%b CN4b=%b AEB=%b",
               i, tbl[i].s, tbl[i].m, tbl[i].cnb, tbl[i].a, tbl[i].b, F, X, Y, CN4b, AEB);
    end

    // Exhaustive sweep with a reset pulse in the middle
    for (int n = 0; n < 16384; n++) begin
      logic [13:0] idx;
      idx = 14'(n);
      apply(idx[3:0], idx[7:4], idx[11:8], idx[12], idx[13]);
      chk_all("sweep", model(idx[3:0], idx[7:4], idx[11:8], idx[12], idx[13]));
`ifdef CIRCUIT_74181B_OUTREG_EN
      if (n == 5000) begin
        // Asynchronous assertion clears outputs before any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", rst_e);
        // Pending result is discarded and reset holds across an edge
        @(posedge clk);
        #1 chk_all("rst_hold", rst_e);
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-sweep reset pulse at vector %0d", n);
      end
`endif
    end
    $display("exhaustive sweep done, checks=%0d", checks);

    // Random back-to-back vectors
    for (int n = 0; n < 500; n++) begin
      logic [3:0] rs, ra, rb;
      logic rm, rc;
      rs = 4'($urandom_range(15)); ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15));
      rm = 1'($urandom_range(1));  rc = 1'($urandom_range(1));
      apply(rs, ra, rb, rm, rc);
      chk_all("rand", model(rs, ra, rb, rm, rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
